mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-port memory between instruction fetch and load/store.
// Load/store has priority; fetch wins once it has been denied STARVE_MAX consecutive cycles.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_be_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  owner_state,
  output logic [3:0]  starve_cnt
);

  // Handshake: a request is accepted in the cycle its gnt is high (req and payload held
  // stable until then); read data is returned exactly one cycle later, qualified by rvalid.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  // Byte-offset bits are dropped: the memory is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], ls_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    mem_be_o    = 4'd0;
    owner_d     = OWN_NONE;
    starve_d    = 4'd0;

    if (!rst_i) begin
      if (if_req_i && (!ls_req_i || starve_q == STARVE_LIM)) begin
        if_gnt_o = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt_o = 1'b1;
      end
    end

    if (if_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {if_addr_i[31:2], 2'b00};
      owner_d    = OWN_IF;
    end else if (ls_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {ls_addr_i[31:2], 2'b00};
      if (ls_we_i) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = ls_wdata_i;
        mem_be_o    = ls_be_i;
      end else begin
        owner_d = OWN_LS;
      end
    end

    // Counts consecutive denied fetch cycles, holding at the limit.
    if (if_req_i && !if_gnt_o) begin
      starve_d = (starve_q < STARVE_LIM) ? starve_q + 4'd1 : starve_q;
    end
  end

  // Reset also masks a response still pending from the cycle before reset rose.
  assign if_rvalid_o = !rst_i && (owner_q == OWN_IF);
  assign ls_rvalid_o = !rst_i && (owner_q == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : 32'd0;

  assign owner_state = owner_q;
  assign starve_cnt  = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_MAX = 4).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic [1:0]  owner_state;
  logic [3:0]  starve_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_if_won;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_be_i(ls_be), .ls_gnt_o(ls_gnt),
    .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .owner_state(owner_state), .starve_cnt(starve_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_be = 4'd0;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
  endtask

  task automatic drive_ls(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check_eq({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    check_eq({tag, "_ls_rvalid"}, {31'd0, ls_rvalid}, 32'd0);
    check_eq({tag, "_starve"}, {28'd0, starve_cnt}, 32'd0);
  endtask

  initial begin
    drive_idle();
    mem_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;

    // Reset with both requesters active: nothing may be granted.
    next_cycle();
    drive_if(32'h40); drive_ls(1'b0, 32'h80, 32'd0, 4'd0);
    #1;
    check_eq("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check_eq("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
    next_cycle();
    #1;
    check_quiet("rst_hold");
    check_eq("rst_owner", {30'd0, owner_state}, 32'd0);

    next_cycle();
    rst = 1'b0; drive_idle();
    #1;
    check_quiet("post_rst");

    // Lone fetch, unaligned address.
    next_cycle();
    drive_if(32'h0000_0006);
    #1;
    check_eq("if_only_gnt", {31'd0, if_gnt}, 32'd1);
    check_eq("if_only_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    check_eq("if_only_en", {31'd0, mem_en}, 32'd1);
    check_eq("if_only_addr", mem_addr, 32'h0000_0004);
    check_eq("if_only_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    drive_idle(); mem_rdata = 32'h0010_0193;
    #1;
    check_eq("if_only_rvalid", {31'd0, if_rvalid}, 32'd1);
    check_eq("if_only_rdata", if_rdata, 32'h0010_0193);
    check_eq("if_only_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    check_eq("if_only_ls_rdata", ls_rdata, 32'd0);

    // Store: completes on grant, no response.
    next_cycle();
    drive_ls(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    #1;
    check_eq("st_gnt", {31'd0, ls_gnt}, 32'd1);
    check_eq("st_we", {31'd0, mem_we}, 32'd1);
    check_eq("st_be", {28'd0, mem_be}, 32'h3);
    check_eq("st_addr", mem_addr, 32'h10);
    check_eq("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    drive_idle(); mem_rdata = 32'h1234_5678;
    #1;
    check_eq("st_no_rvalid", {31'd0, ls_rvalid}, 32'd0);
    check_eq("st_no_rdata", ls_rdata, 32'd0);
    check_eq("st_if_rvalid", {31'd0, if_rvalid}, 32'd0);

    // Load then fetch on consecutive cycles.
    next_cycle();
    drive_ls(1'b0, 32'h23, 32'hCAFE_0000, 4'hF);
    #1;
    check_eq("ld_gnt", {31'd0, ls_gnt}, 32'd1);
    check_eq("ld_addr", mem_addr, 32'h20);
    check_eq("ld_we", {31'd0, mem_we}, 32'd0);
    check_eq("ld_wdata", mem_wdata, 32'd0);
    next_cycle();
    drive_idle(); drive_if(32'h44); mem_rdata = 32'h1111_1111;
    #1;
    check_eq("alt_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    check_eq("alt_ls_rdata", ls_rdata, 32'h1111_1111);
    check_eq("alt_if_rvalid0", {31'd0, if_rvalid}, 32'd0);
    check_eq("alt_if_gnt", {31'd0, if_gnt}, 32'd1);
    check_eq("alt_if_addr", mem_addr, 32'h44);
    next_cycle();
    drive_idle(); mem_rdata = 32'h2222_2222;
    #1;
    check_eq("alt_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check_eq("alt_if_rdata", if_rdata, 32'h2222_2222);
    check_eq("alt_ls_rvalid0", {31'd0, ls_rvalid}, 32'd0);

    // Both request every cycle: ls x4, if on the 5th, ls on the 6th.
    prev_if_won = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      drive_if(32'h100); drive_ls(1'b0, 32'h200, 32'd0, 4'd0);
      mem_rdata = 32'hA000_0000 + k;
      #1;
      if (k >= 2) begin
        check_eq($sformatf("starve_resp_if_%0d", k), {31'd0, if_rvalid}, {31'd0, prev_if_won});
        check_eq($sformatf("starve_resp_ls_%0d", k), {31'd0, ls_rvalid}, {31'd0, !prev_if_won});
        check_eq($sformatf("starve_rdata_%0d", k), prev_if_won ? if_rdata : ls_rdata,
                 exp_q.pop_front());
      end
      check_eq($sformatf("starve_cnt_%0d", k), {28'd0, starve_cnt}, (k <= 5) ? k - 1 : 0);
      check_eq($sformatf("starve_if_gnt_%0d", k), {31'd0, if_gnt}, (k == 5) ? 32'd1 : 32'd0);
      check_eq($sformatf("starve_ls_gnt_%0d", k), {31'd0, ls_gnt}, (k == 5) ? 32'd0 : 32'd1);
      check_eq($sformatf("starve_addr_%0d", k), mem_addr, (k == 5) ? 32'h100 : 32'h200);
      exp_q.push_back(32'hA000_0000 + k + 1);
      prev_if_won = (k == 5);
    end
    next_cycle();
    drive_idle(); mem_rdata = 32'hA000_0007;
    #1;
    check_eq("starve_tail_rvalid", {31'd0, ls_rvalid}, 32'd1);
    check_eq("starve_tail_rdata", ls_rdata, exp_q.pop_front());
    check_eq("starve_tail_cnt", {28'd0, starve_cnt}, 32'd1);
    next_cycle();
    #1;
    check_quiet("starve_clear");

    // Read granted, then reset: the response is suppressed.
    next_cycle();
    drive_if(32'h300);
    #1;
    check_eq("rr_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    rst = 1'b1; drive_idle(); mem_rdata = 32'h5555_5555;
    #1;
    check_eq("rr_rvalid", {31'd0, if_rvalid}, 32'd0);
    check_eq("rr_rdata", if_rdata, 32'd0);
    check_eq("rr_en", {31'd0, mem_en}, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check_quiet("rr_release");
    check_eq("rr_owner", {30'd0, owner_state}, 32'd0);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      mem_rdata = $urandom_range(0, 32'hFFFF);
      #1;
      check_quiet($sformatf("idle_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
